// File: rtl/qarma_pkg.sv
// qarma_pkg: shared widths and loader state encoding for the QARMA operand loader
package qarma_pkg;
    localparam int N         = 64;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 10;
    localparam int KEY_WORDS = 4;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} ld_state_t;
endpackage

// File: rtl/qarma_loader.sv
// qarma_loader: streams 32-bit operand words into the cipher core registers and captures its result
module qarma_loader
    import qarma_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_enc,
    input  logic              cmd_keep_key,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] wr_data,
    output logic              enc,
    output logic [N-1:0]      K0,
    output logic [N-1:0]      K1,
    output logic [N-1:0]      P,
    output logic [N-1:0]      T0,
    output logic [N-1:0]      T1,
    input  logic [N-1:0]      core_c,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N-1:0]      res_data,
    output logic              busy
);
    localparam int CW = $clog2(LAT + 2);
    localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);
    localparam logic [3:0] KEY_IDX  = 4'(KEY_WORDS - 1);

    ld_state_t         state, state_n;
    logic [3:0]        idx;
    logic [CW-1:0]     cnt;
    logic              key_loaded;
    logic [WORD_W-1:0] ops [NUM_WORDS];
    logic              cmd_fire, wr_fire;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign wr_fire  = wr_valid && wr_ready;

    assign K0 = {ops[1], ops[0]};
    assign K1 = {ops[3], ops[2]};
    assign P  = {ops[5], ops[4]};
    assign T0 = {ops[7], ops[6]};
    assign T1 = {ops[9], ops[8]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state and handshake outputs, all derived from registered state only
    always_comb begin
        state_n   = state;
        cmd_ready = state == S_IDLE;
        wr_ready  = state == S_LOAD;
        res_valid = state == S_DONE;
        busy      = state != S_IDLE;
        case (state)
            S_IDLE:  if (cmd_valid) state_n = S_LOAD;
            S_LOAD:  if (wr_valid && idx == LAST_IDX) state_n = S_WAIT;
            S_WAIT:  if (cnt == CW'(1)) state_n = S_DONE;
            S_DONE:  if (res_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Operand, index, latency counter and result capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            cnt        <= '0;
            key_loaded <= 1'b0;
            enc        <= 1'b0;
            res_data   <= '0;
            for (int i = 0; i < NUM_WORDS; i++) ops[i] <= '0;
        end else begin
            if (cmd_fire) begin
                enc <= cmd_enc;
                idx <= (cmd_keep_key && key_loaded) ? 4'(KEY_WORDS) : 4'd0;
            end
            if (wr_fire) begin
                ops[idx] <= wr_data;
                idx      <= idx + 4'd1;
                if (idx == KEY_IDX)  key_loaded <= 1'b1;
                if (idx == LAST_IDX) cnt <= CW'(LAT + 1);
            end
            if (state == S_WAIT) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) res_data <= core_c;
            end
        end
    end
endmodule

// File: tb/tb_qarma_loader.sv
// tb_qarma_loader: directed vector bench for qarma_loader with a toy registered cipher core
module tb_qarma_loader;
    localparam int LAT = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_enc = 1'b0, cmd_keep_key = 1'b0;
    logic        wr_valid = 1'b0, res_ready = 1'b0;
    logic [31:0] wr_data = '0;
    logic        cmd_ready, wr_ready, enc, res_valid, busy;
    logic [63:0] k0, k1, p, t0, t1, core_c, res_data;

    int errors = 0, checks = 0;
    logic [31:0] sup [10];
    logic [63:0] last_rd;

    qarma_loader #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_enc(cmd_enc), .cmd_keep_key(cmd_keep_key),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .enc(enc), .K0(k0), .K1(k1), .P(p), .T0(t0), .T1(t1), .core_c(core_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] cipher(input logic e, input logic [63:0] a, b, pt, ta, tb);
        logic [63:0] x;
        if (e) begin
            x = pt ^ a;
            return ((x << 13) | (x >> 51)) ^ b ^ ta ^ tb;
        end
        x = pt ^ b ^ ta ^ tb;
        return ((x >> 13) | (x << 51)) ^ a;
    endfunction

    // Stand-in core: LAT registered stages from operands to core_c
    logic [63:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= cipher(enc, k0, k1, p, t0, t1);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_c = pipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_cmd(input logic e, input logic k, input int exp_n, input bit tog, input int hold,
                           input bit abort, input logic [63:0] xk0, xk1, xp, xt0, xt1);
        int j, t, edges;
        bit ph, stable;
        logic [63:0] held, xr;
        xr = cipher(e, xk0, xk1, xp, xt0, xt1);
        @(negedge clk);
        wr_valid = 1'b1;
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("idle_wr_ready", 64'(wr_ready), 64'd0);
        cmd_valid = 1'b1; cmd_enc = e; cmd_keep_key = k;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        j = 0; t = 0; ph = 1'b1;
        while (!(j > 0 && !wr_ready) && t < 40) begin
            wr_valid = tog ? ph : 1'b1;
            ph = !ph;
            wr_data = (j < 10) ? sup[j] : (32'hdead0000 | 32'(j));
            if (wr_valid && wr_ready) j++;
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        wr_valid = 1'b0;
        if (t >= 40) begin
            chk("load_timeout", 64'(t), 64'd0);
            return;
        end
        chk("words_accepted", 64'(j), 64'(exp_n));
        if (abort) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            chk("abort_res_valid", 64'(res_valid), 64'd0);
            chk("abort_res_data", res_data, 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
            chk("abort_wr_ready", 64'(wr_ready), 64'd0);
            chk("abort_enc", 64'(enc), 64'd0);
            chk("abort_ops", k0 | k1 | p | t0 | t1, 64'd0);
            stable = 1'b1;
            for (int i = 0; i < LAT + 4; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (res_valid) stable = 1'b0;
            end
            chk("abort_no_result", 64'(stable), 64'd1);
            return;
        end
        edges = 1;
        while (!res_valid && edges < 20) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        chk("result_latency", 64'(edges), 64'(LAT + 2));
        chk("res_valid", 64'(res_valid), 64'd1);
        chk("res_data", res_data, xr);
        chk("enc", 64'(enc), 64'(e));
        chk("K0", k0, xk0);
        chk("K1", k1, xk1);
        chk("P", p, xp);
        chk("T0", t0, xt0);
        chk("T1", t1, xt1);
        last_rd = res_data;
        held = res_data;
        stable = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (cmd_ready || !res_valid || res_data !== held) stable = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("hold_stable", 64'(stable && res_valid && !cmd_ready && res_data === held), 64'd1);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_res_valid", 64'(res_valid), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    typedef struct {
        logic        enc;
        logic        keep;
        logic [31:0] base;
        int          exp_n;
        logic [63:0] xk0, xk1;
        bit          tog;
        int          hold;
    } vec_t;

    vec_t vt [4];

    initial begin
        logic [63:0] pt, ct, q0, q1;
        vt[0] = '{1'b1, 1'b0, 32'h1,   10, 64'h0000000200000001, 64'h0000000400000003, 1'b0, 0};
        vt[1] = '{1'b1, 1'b1, 32'h11,   6, 64'h0000000200000001, 64'h0000000400000003, 1'b0, 2};
        vt[2] = '{1'b0, 1'b0, 32'h100, 10, 64'h0000010100000100, 64'h0000010300000102, 1'b1, 5};
        vt[3] = '{1'b1, 1'b1, 32'h200,  6, 64'h0000010100000100, 64'h0000010300000102, 1'b1, 5};

        do_reset();
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("rst_res_data", res_data, 64'd0);
        chk("rst_ops", k0 | k1 | p | t0 | t1, 64'd0);

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 10; i++) sup[i] = vt[v].base + 32'(vt[v].keep ? i + 4 : i);
            run_cmd(vt[v].enc, vt[v].keep, vt[v].exp_n, vt[v].tog, vt[v].hold, 1'b0,
                    vt[v].xk0, vt[v].xk1,
                    {vt[v].base + 32'd5, vt[v].base + 32'd4},
                    {vt[v].base + 32'd7, vt[v].base + 32'd6},
                    {vt[v].base + 32'd9, vt[v].base + 32'd8});
        end

        // keep_key right after reset must still take all ten words
        do_reset();
        for (int i = 0; i < 10; i++) sup[i] = 32'h300 + 32'(i);
        run_cmd(1'b1, 1'b1, 10, 1'b0, 0, 1'b0, 64'h0000030100000300, 64'h0000030300000302,
                64'h0000030500000304, 64'h0000030700000306, 64'h0000030900000308);
        for (int i = 0; i < 10; i++) sup[i] = 32'h404 + 32'(i);
        run_cmd(1'b0, 1'b1, 6, 1'b0, 1, 1'b0, 64'h0000030100000300, 64'h0000030300000302,
                64'h0000040500000404, 64'h0000040700000406, 64'h0000040900000408);

        // reset one cycle after the last word
        for (int i = 0; i < 10; i++) sup[i] = 32'h500 + 32'(i);
        run_cmd(1'b1, 1'b0, 10, 1'b0, 0, 1'b1, '0, '0, '0, '0, '0);

        // round trip: encrypt then decrypt the model ciphertext with the stored key
        for (int i = 0; i < 10; i++) sup[i] = 32'h600 + 32'(i);
        q0 = 64'h0000060100000600;
        q1 = 64'h0000060300000602;
        pt = 64'h0000060500000604;
        ct = cipher(1'b1, q0, q1, pt, 64'h0000060700000606, 64'h0000060900000608);
        run_cmd(1'b1, 1'b0, 10, 1'b0, 0, 1'b0, q0, q1, pt, 64'h0000060700000606, 64'h0000060900000608);
        sup[0] = ct[31:0];  sup[1] = ct[63:32];
        sup[2] = 32'h606;   sup[3] = 32'h607;
        sup[4] = 32'h608;   sup[5] = 32'h609;
        run_cmd(1'b0, 1'b1, 6, 1'b1, 3, 1'b0, q0, q1, ct, 64'h0000060700000606, 64'h0000060900000608);
        chk("round_trip", last_rd, pt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
